cordic_rom_seq: RTL and testbench

- Sequencer for the cordic_rom sine core.
- Copies the 64-entry x 48-bit LUT from a synchronous source memory into the core's write port, holds the core in reset, then releases it and runs it.
- Forwards exactly NUM samples, or free-runs, with fcw/offset updates by handshake.
- Sits between the host/config logic and the core, replacing bench-driven load sequencing.

---
 rtl/cordic_rom_seq.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_cordic_rom_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rom_seq.sv
// Load/run sequencer for the cordic_rom sine core: copies the LUT image, holds and releases core reset, forwards samples.
// Optional running sample checksum output (csum) is enabled by defining CORDIC_SEQ_CSUM_EN.
module cordic_rom_seq #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 48,
  parameter int PHASE_W = 16,
  parameter int AMP_W   = 16,
  parameter int CNT_W   = 16,
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               skip_load,
  input  logic               stop,
  input  logic [CNT_W-1:0]   num,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_fcw,
  input  logic [PHASE_W-1:0] cfg_offset,
  output logic [ADDR_W-1:0]  src_addr,
  input  logic [DATA_W-1:0]  src_data,
  output logic               core_rst,
  output logic               core_cen,
  output logic               core_wen,
  output logic [ADDR_W-1:0]  core_idx,
  output logic [DATA_W-1:0]  core_d,
  output logic [PHASE_W-1:0] core_fcw,
  output logic [PHASE_W-1:0] core_offset,
  input  logic [AMP_W-1:0]   core_amp,
  input  logic               core_vld,
  output logic               samp_valid,
  output logic [AMP_W-1:0]   samp_data,
  output logic               busy,
  output logic               done,
`ifdef CORDIC_SEQ_CSUM_EN
  output logic [AMP_W-1:0]   csum,
`endif
  output logic               lut_ok
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  src_addr_q, src_addr_d;
  logic               issue_q, issue_d;
  logic               rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]  rd_idx_q, rd_idx_d;
  logic               core_rst_q, core_rst_d;
  logic               core_cen_q, core_cen_d;
  logic               core_wen_q, core_wen_d;
  logic [ADDR_W-1:0]  core_idx_q, core_idx_d;
  logic [DATA_W-1:0]  core_d_q, core_d_d;
  logic [PHASE_W-1:0] core_fcw_q, core_fcw_d;
  logic [PHASE_W-1:0] core_offset_q, core_offset_d;
  logic               samp_valid_q, samp_valid_d;
  logic [AMP_W-1:0]   samp_data_q, samp_data_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               lut_ok_q, lut_ok_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and datapath logic for the load/settle/run sequence.
  always_comb begin
    state_d       = state_q;
    src_addr_d    = src_addr_q;
    issue_d       = issue_q;
    core_idx_d    = core_idx_q;
    core_d_d      = core_d_q;
    core_wen_d    = 1'b1;
    samp_valid_d  = 1'b0;
    samp_data_d   = samp_data_q;
    lut_ok_d      = lut_ok_q;
    num_d         = num_q;
    cnt_d         = cnt_q;
    settle_cnt_d  = settle_cnt_q;
    // A read issued last cycle returns its data this cycle.
    rd_vld_d      = (state_q == S_LOAD) && issue_q && !stop;
    rd_idx_d      = src_addr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d = num;
          if (skip_load && lut_ok_q) begin
            state_d      = S_SETTLE;
            settle_cnt_d = '0;
            cnt_d        = '0;
          end else begin
            state_d    = S_LOAD;
            lut_ok_d   = 1'b0;
            src_addr_d = '0;
            issue_d    = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_d = S_IDLE;
          issue_d = 1'b0;
        end else begin
          if (issue_q) begin
            if (src_addr_q == LAST_IDX) begin
              issue_d = 1'b0;
            end else begin
              src_addr_d = src_addr_q + ADDR_W'(1);
            end
          end else begin
            issue_d = 1'b0;
          end
          if (rd_vld_q) begin
            core_wen_d = 1'b0;
            core_idx_d = rd_idx_q;
            core_d_d   = src_data;
          end else begin
            core_wen_d = 1'b1;
          end
          // The cycle after the top-index write closes the image.
          if (!core_wen_q && (core_idx_q == LAST_IDX)) begin
            state_d      = S_SETTLE;
            lut_ok_d     = 1'b1;
            settle_cnt_d = '0;
            cnt_d        = '0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_SETTLE: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (settle_cnt_q == SET_LAST) begin
          state_d = S_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      S_RUN: begin
        if (core_vld) begin
          samp_valid_d = 1'b1;
          samp_data_d  = core_amp;
          cnt_d        = cnt_inc;
          if ((num_q != '0) && (cnt_inc == num_q)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
        if (stop) begin
          state_d = S_DONE;
        end else begin
          num_d = num_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        issue_d = 1'b0;
      end
    endcase
  end

  // Status, core control and config handshake derived from the next state.
  always_comb begin
    core_rst_d    = (state_d != S_RUN);
    core_cen_d    = (state_d != S_RUN);
    busy_d        = (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_RUN);
    done_d        = (state_d == S_DONE);
    cfg_ready_d   = cfg_valid && !cfg_ready_q && (state_d != S_LOAD);
    core_fcw_d    = core_fcw_q;
    core_offset_d = core_offset_q;
    if (cfg_valid && cfg_ready_q) begin
      core_fcw_d    = cfg_fcw;
      core_offset_d = cfg_offset;
    end else begin
      core_fcw_d    = core_fcw_q;
      core_offset_d = core_offset_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      src_addr_q    <= '0;
      issue_q       <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_idx_q      <= '0;
      core_rst_q    <= 1'b1;
      core_cen_q    <= 1'b1;
      core_wen_q    <= 1'b1;
      core_idx_q    <= '0;
      core_d_q      <= '0;
      core_fcw_q    <= '0;
      core_offset_q <= '0;
      samp_valid_q  <= 1'b0;
      samp_data_q   <= '0;
      cfg_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      lut_ok_q      <= 1'b0;
      num_q         <= '0;
      cnt_q         <= '0;
      settle_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      src_addr_q    <= src_addr_d;
      issue_q       <= issue_d;
      rd_vld_q      <= rd_vld_d;
      rd_idx_q      <= rd_idx_d;
      core_rst_q    <= core_rst_d;
      core_cen_q    <= core_cen_d;
      core_wen_q    <= core_wen_d;
      core_idx_q    <= core_idx_d;
      core_d_q      <= core_d_d;
      core_fcw_q    <= core_fcw_d;
      core_offset_q <= core_offset_d;
      samp_valid_q  <= samp_valid_d;
      samp_data_q   <= samp_data_d;
      cfg_ready_q   <= cfg_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      lut_ok_q      <= lut_ok_d;
      num_q         <= num_d;
      cnt_q         <= cnt_d;
      settle_cnt_q  <= settle_cnt_d;
    end
  end

`ifdef CORDIC_SEQ_CSUM_EN
  logic [AMP_W-1:0] csum_q, csum_d;

  // Running checksum: restarts on SETTLE entry, accumulates each emitted sample.
  always_comb begin
    if ((state_d == S_SETTLE) && (state_q != S_SETTLE)) begin
      csum_d = '0;
    end else if (samp_valid_q) begin
      csum_d = csum_q + samp_data_q;
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`endif

  assign src_addr    = src_addr_q;
  assign core_rst    = core_rst_q;
  assign core_cen    = core_cen_q;
  assign core_wen    = core_wen_q;
  assign core_idx    = core_idx_q;
  assign core_d      = core_d_q;
  assign core_fcw    = core_fcw_q;
  assign core_offset = core_offset_q;
  assign samp_valid  = samp_valid_q;
  assign samp_data   = samp_data_q;
  assign cfg_ready   = cfg_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign lut_ok      = lut_ok_q;

endmodule

// File: tb/tb_cordic_rom_seq.sv
// Scoreboard bench for cordic_rom_seq: expected LUT writes and samples are queued by stimulus, popped by a monitor.
module tb_cordic_rom_seq;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 48;
  localparam int PHASE_W = 16;
  localparam int AMP_W   = 16;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               skip_load = 1'b0;
  logic               stop = 1'b0;
  logic [CNT_W-1:0]   num = '0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_fcw = '0;
  logic [PHASE_W-1:0] cfg_offset = '0;
  logic [ADDR_W-1:0]  src_addr;
  logic [DATA_W-1:0]  src_data = '0;
  logic               core_rst, core_cen, core_wen;
  logic [ADDR_W-1:0]  core_idx;
  logic [DATA_W-1:0]  core_d;
  logic [PHASE_W-1:0] core_fcw, core_offset;
  logic [AMP_W-1:0]   core_amp = '0;
  logic               core_vld = 1'b0;
  logic               samp_valid;
  logic [AMP_W-1:0]   samp_data;
  logic               busy, done, lut_ok;
`ifdef CORDIC_SEQ_CSUM_EN
  logic [AMP_W-1:0]   csum;
  logic [AMP_W-1:0]   csum_model = '0;
`endif

  cordic_rom_seq dut (
    .clk(clk), .reset(reset), .start(start), .skip_load(skip_load), .stop(stop),
    .num(num), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_fcw(cfg_fcw),
    .cfg_offset(cfg_offset), .src_addr(src_addr), .src_data(src_data),
    .core_rst(core_rst), .core_cen(core_cen), .core_wen(core_wen), .core_idx(core_idx),
    .core_d(core_d), .core_fcw(core_fcw), .core_offset(core_offset), .core_amp(core_amp),
    .core_vld(core_vld), .samp_valid(samp_valid), .samp_data(samp_data), .busy(busy),
    .done(done),
`ifdef CORDIC_SEQ_CSUM_EN
    .csum(csum),
`endif
    .lut_ok(lut_ok)
  );

  always #5 clk = ~clk;

  // Source LUT memory: word i = {8{i}}, one-cycle read latency.
  always @(posedge clk) src_data <= {8{src_addr}};

  int tests_run = 0;
  int tests_failed = 0;
  int samp_seen = 0;
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  logic [AMP_W-1:0]         exp_samp_q[$];
  logic [ADDR_W+DATA_W-1:0] wr_e;
  logic [AMP_W-1:0]         samp_e;
  logic [PHASE_W-1:0]       exp_fcw = '0;
  logic [PHASE_W-1:0]       exp_off = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AMP_W-1:0] amp_of(input int k);
    logic [31:0] v;
    v = k * 7;
    return v[AMP_W-1:0] ^ 16'h5a5a;
  endfunction

  task automatic push_writes(input int last);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i <= last; i++) begin
      a = ADDR_W'(i);
      exp_wr_q.push_back({a, {8{a}}});
    end
  endtask

  // Monitor: every DUT write or sample must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (core_wen == 1'b0) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          wr_e = exp_wr_q.pop_front();
          check("wr_idx", 64'(core_idx), 64'(wr_e[ADDR_W+DATA_W-1:DATA_W]));
          check("wr_data", 64'(core_d), 64'(wr_e[DATA_W-1:0]));
        end
      end
      if (samp_valid) begin
        samp_seen++;
        if (exp_samp_q.size() == 0) begin
          check("unexpected_sample", 64'd1, 64'd0);
        end else begin
          samp_e = exp_samp_q.pop_front();
          check("samp_data", 64'(samp_data), 64'(samp_e));
`ifdef CORDIC_SEQ_CSUM_EN
          check("csum", 64'(csum), 64'(csum_model));
          csum_model = csum_model + samp_e;
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int k, input int s_lo, input int s_hi);
    logic acc;
    core_amp = amp_of(k);
    acc = cfg_valid & cfg_ready;
    @(posedge clk);
    if (k >= s_lo && k <= s_hi) exp_samp_q.push_back(amp_of(k));
    #1;
    if (acc) begin
      cfg_valid = 1'b0;
      check("cfg_fcw", 64'(core_fcw), 64'(exp_fcw));
      check("cfg_offset", 64'(core_offset), 64'(exp_off));
    end
  endtask

  task automatic do_start(input logic skip, input logic [CNT_W-1:0] n);
    start = 1'b1;
    skip_load = skip;
    num = n;
    core_amp = amp_of(0);
`ifdef CORDIC_SEQ_CSUM_EN
    csum_model = '0;
`endif
    tick();
    start = 1'b0;
    skip_load = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    check({tag, "_core_cen"}, 64'(core_cen), 64'd1);
    check({tag, "_core_wen"}, 64'(core_wen), 64'd1);
    check({tag, "_src_addr"}, 64'(src_addr), 64'd0);
    check({tag, "_core_fcw"}, 64'(core_fcw), 64'd0);
    check({tag, "_samp_valid"}, 64'(samp_valid), 64'd0);
    check({tag, "_samp_data"}, 64'(samp_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_lut_ok"}, 64'(lut_ok), 64'd0);
    check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
`ifdef CORDIC_SEQ_CSUM_EN
    check({tag, "_csum"}, 64'(csum), 64'd0);
`endif
  endtask

  initial begin
    int base;
    logic ready_leak;
    #1 reset = 1'b1;
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    core_vld = 1'b1;
    tick();

    // Full load with cfg held pending, then counted run of 4096 samples.
    base = samp_seen;
    push_writes(63);
    cfg_valid = 1'b1; cfg_fcw = 16'h0222; cfg_offset = 16'h0333;
    exp_fcw = 16'h0222; exp_off = 16'h0333;
    do_start(1'b0, 16'd4096);
    ready_leak = 1'b0;
    for (int k = 1; k <= 4164; k++) begin
      if (k == 200) begin
        cfg_valid = 1'b1; cfg_fcw = 16'h0111; cfg_offset = 16'h0444;
        exp_fcw = 16'h0111; exp_off = 16'h0444;
      end
      step(k, 69, 4164);
      if (k <= 65 && cfg_ready) ready_leak = 1'b1;
      if (k == 65) begin
        check("lut_ok_k65", 64'(lut_ok), 64'd0);
        check("busy_load", 64'(busy), 64'd1);
      end
      if (k == 66) begin
        check("lut_ok_k66", 64'(lut_ok), 64'd1);
        check("cfg_ready_settle", 64'(cfg_ready), 64'd1);
        check("core_rst_settle", 64'(core_rst), 64'd1);
      end
      if (k == 68) begin
        check("core_rst_run", 64'(core_rst), 64'd0);
        check("core_cen_run", 64'(core_cen), 64'd0);
      end
      if (k == 4163) check("done_early", 64'(done), 64'd0);
    end
    check("cfg_ready_in_load", 64'(ready_leak), 64'd0);
    check("done_count", 64'(done), 64'd1);
    check("cen_done", 64'(core_cen), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    step(4165, 1, 0);
    check("samples_4096", 64'(samp_seen - base), 64'd4096);
    check("samp_q_empty", 64'(exp_samp_q.size()), 64'd0);

    // Skip load, num=3: no writes, two SETTLE cycles, then RUN.
    base = samp_seen;
    do_start(1'b1, 16'd3);
    check("skip_busy", 64'(busy), 64'd1);
    check("skip_done_clr", 64'(done), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      step(k, 3, 5);
      if (k == 1) check("skip_rst_k1", 64'(core_rst), 64'd1);
      if (k == 2) check("skip_rst_k2", 64'(core_rst), 64'd0);
      if (k == 4) check("skip_done_k4", 64'(done), 64'd0);
      if (k == 5) check("skip_done_k5", 64'(done), 64'd1);
    end
    check("samples_3", 64'(samp_seen - base), 64'd3);

    // Abort during LOAD at src_addr=20.
    push_writes(18);
    do_start(1'b0, 16'd0);
    for (int k = 1; k <= 21; k++) begin
      if (k == 21) stop = 1'b1;
      step(k, 1, 0);
      stop = 1'b0;
      if (k == 20) check("abort_src_addr", 64'(src_addr), 64'd20);
    end
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_lut_ok", 64'(lut_ok), 64'd0);
    check("abort_wen", 64'(core_wen), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    tick();
    check("abort_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);

    // skip_load start after abort must reload; free-run then stop with a same-cycle sample.
    base = samp_seen;
    push_writes(63);
    do_start(1'b1, 16'd0);
    for (int k = 1; k <= 81; k++) begin
      if (k == 81) stop = 1'b1;
      step(k, 69, 81);
      stop = 1'b0;
      if (k == 2) check("reload_wen", 64'(core_wen), 64'd0);
      if (k == 66) check("reload_lut_ok", 64'(lut_ok), 64'd1);
    end
    check("stop_done", 64'(done), 64'd1);
    check("stop_last_samp", 64'(samp_valid), 64'd1);
    step(82, 1, 0);
    check("samples_13", 64'(samp_seen - base), 64'd13);

    // Asynchronous reset between edges mid-RUN.
    do_start(1'b1, 16'd0);
    for (int k = 1; k <= 10; k++) step(k, 3, 10);
    check("pre_rst_run", 64'(core_cen), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    exp_samp_q.delete();
    check_reset_vals("async");
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_lut_ok", 64'(lut_ok), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
